// File: rtl/imm_arb_ctrl_pkg.sv
// Shared definitions for the arbitrated immediate-generation controller:
// instruction-format enum, RV32I opcode constants and the opcode classifier.
package imm_arb_ctrl_pkg;

  localparam int IMM_W = 32;

  // Encoding is visible on out_fmt, so values are fixed explicitly.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: decode_fmt = FMT_I;
      OP_STORE:                            decode_fmt = FMT_S;
      OP_BRANCH:                           decode_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    decode_fmt = FMT_U;
      OP_JAL:                              decode_fmt = FMT_J;
      default:                             decode_fmt = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_arb_ctrl_signex12.sv
// 12-bit to IMM_W-bit sign extender, shared by the I and S immediate paths.
//   imm12_i : 12-bit immediate field
//   imm32_o : field with bit 11 replicated up to IMM_W bits
module imm_arb_ctrl_signex12
  import imm_arb_ctrl_pkg::*;
(
  input  logic [11:0]      imm12_i,
  output logic [IMM_W-1:0] imm32_o
);

  assign imm32_o = {{(IMM_W-12){imm12_i[11]}}, imm12_i};

endmodule

// File: rtl/imm_arb_ctrl.sv
// Arbitrated immediate-generation controller. Two requesters share one
// immediate unit; a round-robin arbiter picks one, its instruction format is
// classified, the sign-extended immediate is built and the result is held in
// a registered valid/ready output stage.
//   clk, rst            : clock, synchronous active-high reset
//   reqN_valid/ready    : requester N handshake (N = 0 decode, 1 CSR/LSU)
//   reqN_instr/tag      : requester N instruction word and tag
//   out_valid/ready     : result handshake
//   out_imm/fmt/illegal : immediate, format code, unrecognised opcode flag
//   out_src/tag         : requester and tag that produced the result
//   conflict_cnt        : saturating count of cycles where a valid requester lost
module imm_arb_ctrl
  import imm_arb_ctrl_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_instr,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_instr,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IMM_W-1:0] out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Registered state
  logic             out_valid_q,   out_valid_d;
  logic [IMM_W-1:0] out_imm_q,     out_imm_d;
  fmt_e             out_fmt_q,     out_fmt_d;
  logic             out_illegal_q, out_illegal_d;
  logic             out_src_q,     out_src_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             rr_q,          rr_d;

  // Arbitration
  logic             accept;
  logic             both_valid;
  logic             grant;
  logic             grant_sel;
  logic [31:0]      gnt_instr;
  logic [TAG_W-1:0] gnt_tag;

  // Output register can take a new result when empty or being drained.
  assign accept     = !out_valid_q || out_ready;
  assign both_valid = req0_valid && req1_valid;
  assign grant      = accept && (req0_valid || req1_valid);
  // With a single valid requester it wins outright; on a tie rr_q decides.
  assign grant_sel  = both_valid ? rr_q : req1_valid;
  assign gnt_instr  = grant_sel ? req1_instr : req0_instr;
  assign gnt_tag    = grant_sel ? req1_tag   : req0_tag;

  assign req0_ready = grant && !grant_sel;
  assign req1_ready = grant &&  grant_sel;

  // Decode and immediate build
  fmt_e             fmt;
  logic [11:0]      imm12;
  logic [IMM_W-1:0] imm_sx12;
  logic [IMM_W-1:0] imm;

  assign fmt = decode_fmt(gnt_instr[6:0]);

  // I and S differ only in where the low five bits live, so one extender serves both.
  assign imm12 = (fmt == FMT_S) ? {gnt_instr[31:25], gnt_instr[11:7]}
                                : gnt_instr[31:20];

  imm_arb_ctrl_signex12 u_signex12 (
    .imm12_i (imm12),
    .imm32_o (imm_sx12)
  );

  // NOTE: every output of a combinational block gets a default first, otherwise
  // any path that skips an assignment infers a latch.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I, FMT_S: imm = imm_sx12;
      FMT_B: imm = {{(IMM_W-12){gnt_instr[31]}}, gnt_instr[7],
                    gnt_instr[30:25], gnt_instr[11:8], 1'b0};
      FMT_U: imm = {gnt_instr[31:12], 12'b0};
      FMT_J: imm = {{(IMM_W-20){gnt_instr[31]}}, gnt_instr[19:12],
                    gnt_instr[20], gnt_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Next-state logic: hold by default so backpressure keeps out_* bit-stable.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_imm_d     = out_imm_q;
    out_fmt_d     = out_fmt_q;
    out_illegal_d = out_illegal_q;
    out_src_d     = out_src_q;
    out_tag_d     = out_tag_q;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    if (grant) begin
      out_valid_d   = 1'b1;
      out_imm_d     = imm;
      out_fmt_d     = fmt;
      out_illegal_d = (fmt == FMT_NONE);
      out_src_d     = grant_sel;
      out_tag_d     = gnt_tag;
      rr_d          = !grant_sel;
      // The losing requester stalls; a requester blocked by backpressure does not count.
      if (both_valid && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= FMT_NONE;
      out_illegal_q <= 1'b0;
      out_src_q     <= 1'b0;
      out_tag_q     <= '0;
      cnt_q         <= '0;
      rr_q          <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_imm_q     <= out_imm_d;
      out_fmt_q     <= out_fmt_d;
      out_illegal_q <= out_illegal_d;
      out_src_q     <= out_src_d;
      out_tag_q     <= out_tag_d;
      cnt_q         <= cnt_d;
      rr_q          <= rr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_imm      = out_imm_q;
  assign out_fmt      = out_fmt_q;
  assign out_illegal  = out_illegal_q;
  assign out_src      = out_src_q;
  assign out_tag      = out_tag_q;
  assign conflict_cnt = cnt_q;

endmodule
